// File: rtl/uart_rx_serial.sv
// rtl/uart_rx_serial.sv - oversampling 8N1 UART receiver with valid/ready byte output
// Holding register takes one byte; error/overrun flags are single-cycle pulses.
module uart_rx_serial #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       brk,
  output logic       overrun
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_rxs;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [1:0]        r_samp;
  logic [SC_W-1:0]   r_scnt;
  logic [SC_W-1:0]   w_scnt_nxt;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        r_shift;
  logic              r_deliver;
  logic [7:0]        r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_brk;
  logic              r_overrun;
  logic              w_tick;
  logic              w_maj;
  logic              w_shift_en;
  logic              w_stop_ok;
  logic              w_stop_bad;
  logic              w_clr_div;

  assign w_tick = (r_div_cnt == DIV_LAST);
  // Vote over this tick's sample and the two previous tick samples.
  assign w_maj  = (r_rxs & r_samp[0]) | (r_rxs & r_samp[1]) | (r_samp[0] & r_samp[1]);

  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bit_nxt   = r_bit;
    w_shift_en  = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    w_clr_div   = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_state_nxt = S_START;
            w_scnt_nxt  = SC_W'(1);
            w_clr_div   = 1'b1;
          end
        end
        S_START: begin
          if (r_scnt == SC_HALF) begin
            if (!w_maj) begin
              w_state_nxt = S_DATA;
              w_scnt_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (r_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_scnt_nxt = r_scnt + SC_W'(1);
          end
        end
        S_DATA: begin
          if (r_scnt == SC_LAST) begin
            w_shift_en = 1'b1;
            w_scnt_nxt = '0;
            if (r_bit == 3'd7) w_state_nxt = S_STOP;
            else               w_bit_nxt   = r_bit + 3'd1;
          end else begin
            w_scnt_nxt = r_scnt + SC_W'(1);
          end
        end
        S_STOP: begin
          if (r_scnt == SC_LAST) begin
            w_scnt_nxt = '0;
            if (w_maj) begin
              w_stop_ok   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_stop_bad  = 1'b1;
              w_state_nxt = S_WAIT_HI;
            end
          end else begin
            w_scnt_nxt = r_scnt + SC_W'(1);
          end
        end
        S_WAIT_HI: begin
          if (r_rxs) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_rxs       <= 1'b1;
      r_div_cnt   <= '0;
      r_samp      <= 2'b11;
      r_scnt      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_deliver   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_brk       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      if (w_tick || w_clr_div) r_div_cnt <= '0;
      else                     r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (w_tick) r_samp <= {r_samp[0], r_rxs};
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_bit   <= w_bit_nxt;
      if (w_shift_en) r_shift <= {w_maj, r_shift[7:1]};
      r_deliver   <= w_stop_ok;
      r_frame_err <= w_stop_bad;
      r_brk       <= w_stop_bad && (r_shift == 8'h00);
      // Shift register is untouched until the next DATA phase, so it is still valid here.
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign brk       = r_brk;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_serial.sv
// tb/tb_uart_rx_serial.sv - directed bench for uart_rx_serial at DIV=1, 16 clks per bit
// Pulse counters run on the falling edge; each step compares counter deltas against hand values.
module tb_uart_rx_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       brk;
  logic       overrun;

  uart_rx_serial #(
    .CLK_HZ(1843200),
    .BAUD(115200),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .brk(brk),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_vrise = 0, n_acc = 0, n_fe = 0, n_brk = 0, n_ovr = 0;
  int rise_cyc = 0;
  logic [7:0] last_acc = 8'h00;
  logic prev_valid = 1'b0;
  int b_vrise, b_acc, b_fe, b_brk, b_ovr;
  int stop_start;
  int lag;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      n_vrise  = n_vrise + 1;
      rise_cyc = cyc;
    end
    if (rx_valid && rx_ready) begin
      n_acc    = n_acc + 1;
      last_acc = rx_data;
    end
    if (frame_err) n_fe = n_fe + 1;
    if (brk)       n_brk = n_brk + 1;
    if (overrun)   n_ovr = n_ovr + 1;
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_vrise = n_vrise;
    b_acc   = n_acc;
    b_fe    = n_fe;
    b_brk   = n_brk;
    b_ovr   = n_ovr;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    clks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      clks(16);
    end
    stop_start = cyc;
    rxd = stop_bit;
    clks(16);
    rxd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    clks(3);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_flags", {frame_err, brk, overrun}, 3'b000);
    rst = 1'b0;
    clks(5);

    // 1: single byte, consumer ready
    rx_ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b1);
    clks(20);
    check("t1_rise", n_vrise - b_vrise, 1);
    check("t1_acc", n_acc - b_acc, 1);
    check("t1_data", last_acc, 8'h55);
    check("t1_flags", (n_fe - b_fe) + (n_brk - b_brk) + (n_ovr - b_ovr), 0);
    check("t1_valid_low", rx_valid, 1'b0);
    lag = rise_cyc - (stop_start + 8);
    check("t1_latency", (lag >= 3 && lag <= 11), 1'b1);

    // 2: overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h03, 1'b1);
    clks(20);
    check("t2_valid1", rx_valid, 1'b1);
    check("t2_data1", rx_data, 8'h03);
    send_frame(8'h41, 1'b1);
    clks(20);
    check("t2_ovr", n_ovr - b_ovr, 1);
    check("t2_data_kept", rx_data, 8'h03);
    check("t2_valid_held", rx_valid, 1'b1);
    check("t2_rise_once", n_vrise - b_vrise, 1);
    rx_ready = 1'b1;
    clks(2);
    check("t2_acc", n_acc - b_acc, 1);
    check("t2_acc_data", last_acc, 8'h03);
    check("t2_valid_drop", rx_valid, 1'b0);

    // 3: short glitch rejected, then a clean frame
    snap();
    rxd = 1'b0;
    clks(5);
    rxd = 1'b1;
    clks(30);
    check("t3_no_rise", n_vrise - b_vrise, 0);
    check("t3_no_flags", (n_fe - b_fe) + (n_brk - b_brk) + (n_ovr - b_ovr), 0);
    send_frame(8'hA7, 1'b1);
    clks(20);
    check("t3_acc", n_acc - b_acc, 1);
    check("t3_data", last_acc, 8'hA7);

    // 4: long break
    snap();
    rxd = 1'b0;
    clks(640);
    rxd = 1'b1;
    clks(40);
    check("t4_fe", n_fe - b_fe, 1);
    check("t4_brk", n_brk - b_brk, 1);
    check("t4_no_rise", n_vrise - b_vrise, 0);
    send_frame(8'h0D, 1'b1);
    clks(20);
    check("t4_acc", n_acc - b_acc, 1);
    check("t4_data", last_acc, 8'h0D);

    // 5: bad stop bit with nonzero data
    snap();
    send_frame(8'h80, 1'b0);
    clks(20);
    check("t5_fe", n_fe - b_fe, 1);
    check("t5_brk", n_brk - b_brk, 0);
    check("t5_no_rise", n_vrise - b_vrise, 0);

    // 6: reset during data bit 3 of 0xF8 while holding 0x5A
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    clks(20);
    check("t6_hold_valid", rx_valid, 1'b1);
    check("t6_hold_data", rx_data, 8'h5A);
    rxd = 1'b0;
    clks(16);
    rxd = 1'b0;
    clks(48);
    rxd = 1'b1;
    clks(8);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    check("t6_rst_valid", rx_valid, 1'b0);
    check("t6_rst_data", rx_data, 8'h00);
    check("t6_rst_flags", {frame_err, brk, overrun}, 3'b000);
    snap();
    clks(8 + 64 + 16 + 20);
    check("t6_no_rise", n_vrise - b_vrise, 0);
    check("t6_no_flags", (n_fe - b_fe) + (n_brk - b_brk) + (n_ovr - b_ovr), 0);
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    clks(20);
    check("t6_acc", n_acc - b_acc, 1);
    check("t6_data", last_acc, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
